// File: rtl/mdu_seq_ctrl.sv
// Sequencer for the multi-cycle multiply/divide unit in the E stage: qualifies launches,
// runs the busy window, flags the HI/LO commit edge and raises the D-stage MD hazard stall.
module mdu_seq_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Req,
    input  logic             E_adv,
    input  logic [4:0]       E_ExcCode,
    input  logic             E_MDU_start,
    input  logic [2:0]       E_MDU_op,
    input  logic             D_MDU_use,
    output logic             MDU_launch,
    output logic             MDU_mt_we,
    output logic             MDU_busy,
    output logic             MDU_commit,
    output logic [2:0]       MDU_op_lat,
    output logic [CNT_W-1:0] MDU_cnt,
    output logic             MDU_stall
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZRO = CNT_W'(0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [2:0]       op_r, op_n;
    logic             ok_s, is_mult_s, is_div_s, is_mt_s;
    logic             launch_s, mt_we_s, commit_s, busy_s;

    // Flushed (Req), excepting or non-advancing instructions never reach the MDU.
    assign ok_s      = E_MDU_start & E_adv & ~Req & (E_ExcCode == 5'd0);
    assign is_mult_s = (E_MDU_op == 3'd1) | (E_MDU_op == 3'd2);
    assign is_div_s  = (E_MDU_op == 3'd3) | (E_MDU_op == 3'd4);
    assign is_mt_s   = (E_MDU_op == 3'd5) | (E_MDU_op == 3'd6);

    // State, counter and latched-op registers; reset abandons any in-flight op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZRO;
            op_r    <= 3'd0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            op_r    <= op_n;
        end
    end

    // Next-state logic and the combinational strobes; strobes are held low during reset.
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        op_n     = op_r;
        launch_s = 1'b0;
        mt_we_s  = 1'b0;
        commit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (reset && ok_s && (is_mult_s || is_div_s)) begin
                    launch_s = 1'b1;
                    state_n  = RUN;
                    cnt_n    = is_mult_s ? MULT_LD : DIV_LD;
                    op_n     = E_MDU_op;
                end else if (reset && ok_s && is_mt_s) begin
                    mt_we_s = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                // Start requests while running are ignored; the stall keeps them out of E.
                if (cnt_r == CNT_ONE) begin
                    commit_s = reset;
                    state_n  = IDLE;
                    cnt_n    = CNT_ZRO;
                end else if (cnt_r != CNT_ZRO) begin
                    cnt_n = cnt_r - CNT_ONE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = CNT_ZRO;
            end
        endcase
    end

    assign busy_s     = (state_r == RUN);
    assign MDU_busy   = busy_s;
    assign MDU_cnt    = cnt_r;
    assign MDU_op_lat = op_r;
    assign MDU_launch = launch_s;
    assign MDU_mt_we  = mt_we_s;
    assign MDU_commit = commit_s;
    // Busy is already low in the cycle after commit, so a following mf* reads fresh HI/LO.
    assign MDU_stall  = D_MDU_use & (launch_s | busy_s);

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Directed bench for mdu_seq_ctrl: hand-computed launch/busy/count/commit/stall expectations.
module tb_mdu_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       Req;
    logic       E_adv;
    logic [4:0] E_ExcCode;
    logic       E_MDU_start;
    logic [2:0] E_MDU_op;
    logic       D_MDU_use;
    logic       MDU_launch;
    logic       MDU_mt_we;
    logic       MDU_busy;
    logic       MDU_commit;
    logic [2:0] MDU_op_lat;
    logic [3:0] MDU_cnt;
    logic       MDU_stall;

    int n_vec;
    int n_miss;

    mdu_seq_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Req        (Req),
        .E_adv      (E_adv),
        .E_ExcCode  (E_ExcCode),
        .E_MDU_start(E_MDU_start),
        .E_MDU_op   (E_MDU_op),
        .D_MDU_use  (D_MDU_use),
        .MDU_launch (MDU_launch),
        .MDU_mt_we  (MDU_mt_we),
        .MDU_busy   (MDU_busy),
        .MDU_commit (MDU_commit),
        .MDU_op_lat (MDU_op_lat),
        .MDU_cnt    (MDU_cnt),
        .MDU_stall  (MDU_stall)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic start, input logic [2:0] op, input logic adv,
                         input logic req, input logic [4:0] exc, input logic duse);
        E_MDU_start = start;
        E_MDU_op    = op;
        E_adv       = adv;
        Req         = req;
        E_ExcCode   = exc;
        D_MDU_use   = duse;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},   {31'd0, MDU_busy},   32'd0);
        check({tag, "_cnt"},    {28'd0, MDU_cnt},    32'd0);
        check({tag, "_commit"}, {31'd0, MDU_commit}, 32'd0);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        // Reset: a fully qualified mult must not launch while reset is low.
        reset = 1'b0;
        drive(1'b1, 3'd1, 1'b1, 1'b0, 5'd0, 1'b1);
        #12;
        check("rst_launch", {31'd0, MDU_launch}, 32'd0);
        check("rst_stall",  {31'd0, MDU_stall},  32'd0);
        check("rst_oplat",  {29'd0, MDU_op_lat}, 32'd0);
        check_idle("rst");
        drive(1'b0, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        next_cycle();
        reset = 1'b1;

        // Test 1: mult, busy 5 cycles counting 5..1, commit on cnt==1.
        drive(1'b1, 3'd1, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("t1_launch", {31'd0, MDU_launch}, 32'd1);
        check("t1_busy0",  {31'd0, MDU_busy},   32'd0);
        next_cycle();
        drive(1'b0, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        for (int k = 5; k >= 1; k--) begin
            @(negedge clk);
            check("t1_busy",   {31'd0, MDU_busy},   32'd1);
            check("t1_cnt",    {28'd0, MDU_cnt},    k);
            check("t1_commit", {31'd0, MDU_commit}, (k == 1) ? 32'd1 : 32'd0);
            check("t1_oplat",  {29'd0, MDU_op_lat}, 32'd1);
            next_cycle();
        end
        @(negedge clk);
        check_idle("t1_end");

        // Test 2: divu with D_MDU_use: stall in launch cycle plus 10 busy cycles.
        next_cycle();
        drive(1'b1, 3'd4, 1'b1, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        check("t2_launch", {31'd0, MDU_launch}, 32'd1);
        check("t2_stall0", {31'd0, MDU_stall},  32'd1);
        next_cycle();
        drive(1'b0, 3'd0, 1'b1, 1'b0, 5'd0, 1'b1);
        for (int k = 10; k >= 1; k--) begin
            @(negedge clk);
            check("t2_stall", {31'd0, MDU_stall}, 32'd1);
            check("t2_cnt",   {28'd0, MDU_cnt},   k);
            next_cycle();
        end
        @(negedge clk);
        check("t2_stall_after", {31'd0, MDU_stall}, 32'd0);
        check("t2_oplat",       {29'd0, MDU_op_lat}, 32'd4);
        check_idle("t2_end");

        // Test 3: flushed by Req, then by exception, then held by E_adv=0 and retried.
        next_cycle();
        drive(1'b1, 3'd1, 1'b1, 1'b1, 5'd0, 1'b1);
        @(negedge clk);
        check("t3_req_launch", {31'd0, MDU_launch}, 32'd0);
        check("t3_req_stall",  {31'd0, MDU_stall},  32'd0);
        next_cycle();
        drive(1'b1, 3'd1, 1'b1, 1'b0, 5'd4, 1'b0);
        @(negedge clk);
        check("t3_exc_launch", {31'd0, MDU_launch}, 32'd0);
        check_idle("t3_req_after");
        next_cycle();
        drive(1'b1, 3'd2, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("t3_noadv_launch", {31'd0, MDU_launch}, 32'd0);
        check_idle("t3_exc_after");
        next_cycle();
        check("t3_noadv_busy", {31'd0, MDU_busy}, 32'd0);
        E_adv = 1'b1;
        @(negedge clk);
        check("t3_retry_launch", {31'd0, MDU_launch}, 32'd1);
        next_cycle();
        drive(1'b0, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        check("t3_retry_oplat", {29'd0, MDU_op_lat}, 32'd2);
        for (int k = 0; k < 5; k++) next_cycle();
        @(negedge clk);
        check_idle("t3_retry_end");

        // Test 4: mthi/mtlo are single-cycle writes; ops 0 and 7 do nothing.
        next_cycle();
        drive(1'b1, 3'd5, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("t4_mthi_we",     {31'd0, MDU_mt_we},  32'd1);
        check("t4_mthi_launch", {31'd0, MDU_launch}, 32'd0);
        next_cycle();
        drive(1'b0, 3'd0, 1'b1, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        check("t4_mthi_stall", {31'd0, MDU_stall}, 32'd0);
        check("t4_mthi_we_off", {31'd0, MDU_mt_we}, 32'd0);
        check_idle("t4_mthi_after");
        next_cycle();
        drive(1'b1, 3'd6, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("t4_mtlo_we", {31'd0, MDU_mt_we}, 32'd1);
        next_cycle();
        drive(1'b1, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("t4_op0_launch", {31'd0, MDU_launch}, 32'd0);
        check("t4_op0_we",     {31'd0, MDU_mt_we},  32'd0);
        next_cycle();
        drive(1'b1, 3'd7, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("t4_op7_launch", {31'd0, MDU_launch}, 32'd0);
        check("t4_op7_we",     {31'd0, MDU_mt_we},  32'd0);
        next_cycle();
        check_idle("t4_op7_after");

        // Test 5: div; Req and a stray start at cnt==7 neither abort nor relaunch.
        drive(1'b1, 3'd3, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check("t5_launch", {31'd0, MDU_launch}, 32'd1);
        next_cycle();
        drive(1'b0, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        for (int k = 10; k >= 1; k--) begin
            if (k == 7) drive(1'b1, 3'd1, 1'b1, 1'b1, 5'd0, 1'b0);
            else if (k == 6) drive(1'b1, 3'd5, 1'b1, 1'b0, 5'd0, 1'b0);
            else drive(1'b0, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0);
            @(negedge clk);
            check("t5_cnt",    {28'd0, MDU_cnt},    k);
            check("t5_launch_run", {31'd0, MDU_launch}, 32'd0);
            check("t5_we_run", {31'd0, MDU_mt_we},  32'd0);
            check("t5_commit", {31'd0, MDU_commit}, (k == 1) ? 32'd1 : 32'd0);
            check("t5_oplat",  {29'd0, MDU_op_lat}, 32'd3);
            next_cycle();
        end
        drive(1'b0, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check_idle("t5_end");

        // Test 6: async reset at cnt==4 abandons the div with no later commit.
        next_cycle();
        drive(1'b1, 3'd3, 1'b1, 1'b0, 5'd0, 1'b0);
        next_cycle();
        drive(1'b0, 3'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        for (int k = 10; k > 4; k--) next_cycle();
        @(negedge clk);
        check("t6_cnt_pre", {28'd0, MDU_cnt}, 32'd4);
        #1;
        reset = 1'b0;
        #1;
        check("t6_oplat", {29'd0, MDU_op_lat}, 32'd0);
        check_idle("t6_rst");
        next_cycle();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_idle("t6_post");
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
